qracc_seq_ctrl: RTL
===================

# qracc_seq_ctrl

Sequencer directly downstream of the QrAccelerator CSR block. It consumes the CSR start trigger, soft clear and job configuration, then issues a run of row-fetch requests to the input buffer and array over a valid/ready channel. It tracks in-flight requests against their responses and reports busy, done and error status back to the CSR status register.

## Interface
Parameters:
- ADDR_W, 16, fetch address width
- CNT_W, 12, width of row and tile counts
- MAX_OUT, 4, maximum in-flight requests (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  one-cycle trigger pulse from CSR
- clear_i  in  1  one-cycle soft clear from CSR
- cfg_num_rows_i  in  CNT_W  rows per tile
- cfg_num_tiles_i  in  CNT_W  tile count
- cfg_base_addr_i  in  ADDR_W  first fetch address
- req_valid_o  out  1  fetch request valid
- req_ready_i  in  1  downstream accepts request
- req_addr_o  out  ADDR_W  fetch address
- req_last_o  out  1  marks the final request of the job
- resp_valid_i  in  1  one response per accepted request, in order
- busy_o  out  1  job active (feeds CSR busy)
- done_pulse_o  out  1  one-cycle completion strobe
- status_done_o  out  1  sticky done flag
- status_err_o  out  1  sticky error flag (zero-size job)
- perf_cycles_o  out  32  busy-cycle counter (see Configuration)

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- Reset: state is IDLE. All outputs are 0. The address counter, issue counters and outstanding counter are 0.
- Config is latched on the accepted start. CSR changes made mid-job have no effect on the running job.
- IDLE or DONE with start_i:
  - If either count is 0, go to DONE with status_err_o=1. No requests are issued.
  - Otherwise go to ISSUE. Clear the sticky flags and load addr=cfg_base_addr_i.
- ISSUE:
  - req_valid_o = (outstanding < MAX_OUT).
  - On handshake: addr+1 (mod 2^ADDR_W, wraps silently), advance row/tile counters, outstanding+1.
  - Total requests per job = rows×tiles.
  - req_last_o is high on the final request. After its handshake, go to DRAIN.
- resp_valid_i decrements outstanding. A handshake and a response in the same cycle leave outstanding unchanged.
- DRAIN: when outstanding==0 (including a final response arriving this cycle), go to DONE.
- DONE (one cycle): done_pulse_o=1, status_done_o set, busy_o=0, then IDLE. start_i in DONE starts a new job.
- start_i in ISSUE/DRAIN is ignored.
- clear_i in any state:
  - Go to IDLE and zero outstanding, counters and sticky flags.
  - Takes priority over start_i in the same cycle.
  - Responses arriving in IDLE are dropped; outstanding never underflows (saturates at 0).
- A response with outstanding==0 outside IDLE is a protocol violation. Flag it with an assertion; the counter holds 0.
- busy_o = state is ISSUE or DRAIN.

## Timing
- start_i at cycle N → busy_o=1 and req_valid_o=1 with addr=base at N+1.
- With req_ready_i held high and responses arriving within MAX_OUT cycles, one request is issued per cycle.
- Final response at cycle M → done_pulse_o=1 and busy_o=0 at M+1; IDLE at M+2.
- Zero-size start at N → DONE at N+1 (done_pulse_o and status_err_o high); busy_o never asserts.
- Request outputs are registered and must stay stable while req_valid_o=1 and req_ready_i=0.
- clear_i at N → all outputs at reset values at N+1, except perf_cycles_o.

## Configuration
- QRACC_SEQ_PERF_EN defined:
  - perf_cycles_o increments on each cycle with busy_o=1, wrapping at 2^32.
  - It is zeroed on an accepted start and on rst, and holds its value across clear_i.
- Undefined: perf_cycles_o is tied to 0 and no counter is synthesized.

## Test plan
- rows=3, tiles=2, base=0x0010, ready=1, each response 2 cycles after its handshake → six requests at addresses 0x0010–0x0015, req_last_o only on 0x0015, one done_pulse_o, status_done_o=1.
- MAX_OUT=4, responses withheld → exactly four handshakes, then req_valid_o=0. Releasing one response → exactly one more request is issued.
- base=0xFFFE, rows=4, tiles=1 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- rows=0, tiles=5 → done_pulse_o at N+1, status_err_o=1, zero requests issued.
- clear_i asserted in the same cycle as start_i during ISSUE with 2 outstanding → IDLE next cycle, busy_o=0. Later stray responses are ignored; the next job completes normally.
- With QRACC_SEQ_PERF_EN, rows=2, tiles=1, ready=1, responses 1 cycle after handshake → perf_cycles_o=3 at done. Without the macro → 0.

Source files
------------

// File: rtl/qracc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : qracc_seq_ctrl
// Purpose  : Job sequencer behind the QrAccelerator CSR block. It latches the
//            job configuration on start and issues rows x tiles row-fetch
//            requests on a valid/ready channel. It keeps at most MAX_OUT
//            requests in flight, which are retired by in-order responses.
//            It reports busy, done and error status back to the CSRs.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            start_i, clear_i    - CSR trigger and soft clear (1-cycle pulses)
//            cfg_*_i             - rows per tile, tile count, base address
//            req_valid_o/req_ready_i/req_addr_o/req_last_o - fetch channel
//            resp_valid_i        - one in-order response per accepted request
//            busy_o, done_pulse_o, status_done_o, status_err_o - status
//            perf_cycles_o       - busy-cycle counter
// Options  : QRACC_SEQ_PERF_EN   - when defined, perf_cycles_o counts busy
//                                  cycles; otherwise it is tied to zero
// Revision : 1.0 - initial release
// ============================================================================
module qracc_seq_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int CNT_W   = 12,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic [CNT_W-1:0]  cfg_num_rows_i,
  input  logic [CNT_W-1:0]  cfg_num_tiles_i,
  input  logic [ADDR_W-1:0] cfg_base_addr_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic              req_last_o,
  input  logic              resp_valid_i,
  output logic              busy_o,
  output logic              done_pulse_o,
  output logic              status_done_o,
  output logic              status_err_o,
  output logic [31:0]       perf_cycles_o
);

  localparam int              OUT_W     = $clog2(MAX_OUT + 1);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rows_q, rows_d;
  logic [CNT_W-1:0]  tiles_q, tiles_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  tile_q, tile_d;
  logic [OUT_W-1:0]  outs_q, outs_d;
  logic              sdone_q, sdone_d;
  logic              serr_q, serr_d;

  logic busy;
  logic req_valid;
  logic row_wrap;
  logic is_last;
  logic hs;

  // All request-side outputs are functions of registered state only, so they
  // cannot glitch with req_ready_i and stay stable while a request stalls.
  assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign req_valid = (state_q == ISSUE) && (outs_q < MAX_OUT_C);
  assign row_wrap  = (row_q == rows_q - CNT_W'(1));
  assign is_last   = row_wrap && (tile_q == tiles_q - CNT_W'(1));
  assign hs        = req_valid && req_ready_i;

  assign req_valid_o   = req_valid;
  assign req_addr_o    = addr_q;
  assign req_last_o    = req_valid && is_last;
  assign busy_o        = busy;
  assign done_pulse_o  = (state_q == DONE);
  assign status_done_o = sdone_q;
  assign status_err_o  = serr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rows_d  = rows_q;
    tiles_d = tiles_q;
    row_d   = row_q;
    tile_d  = tile_q;
    outs_d  = outs_q;
    sdone_d = sdone_q;
    serr_d  = serr_q;

    // Simultaneous issue and retire cancel; retiring at zero saturates.
    if (hs && !resp_valid_i) begin
      outs_d = outs_q + OUT_W'(1);
    end else if (!hs && resp_valid_i && (outs_q != '0)) begin
      outs_d = outs_q - OUT_W'(1);
    end

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        if (start_i) begin
          rows_d  = cfg_num_rows_i;
          tiles_d = cfg_num_tiles_i;
          row_d   = '0;
          tile_d  = '0;
          if ((cfg_num_rows_i == '0) || (cfg_num_tiles_i == '0)) begin
            state_d = DONE;
            sdone_d = 1'b1;
            serr_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            addr_d  = cfg_base_addr_i;
            sdone_d = 1'b0;
            serr_d  = 1'b0;
          end
        end
      end
      ISSUE: begin
        if (hs) begin
          addr_d = addr_q + ADDR_W'(1);
          if (row_wrap) begin
            row_d  = '0;
            tile_d = tile_q + CNT_W'(1);
          end else begin
            row_d  = row_q + CNT_W'(1);
          end
          if (is_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // outs_d already accounts for a final response arriving this cycle.
        if (outs_d == '0) begin
          state_d = DONE;
          sdone_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Soft clear overrides everything, including a same-cycle start.
    if (clear_i) begin
      state_d = IDLE;
      addr_d  = '0;
      rows_d  = '0;
      tiles_d = '0;
      row_d   = '0;
      tile_d  = '0;
      outs_d  = '0;
      sdone_d = 1'b0;
      serr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rows_q  <= '0;
      tiles_q <= '0;
      row_q   <= '0;
      tile_q  <= '0;
      outs_q  <= '0;
      sdone_q <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rows_q  <= rows_d;
      tiles_q <= tiles_d;
      row_q   <= row_d;
      tile_q  <= tile_d;
      outs_q  <= outs_d;
      sdone_q <= sdone_d;
      serr_q  <= serr_d;
    end
  end

`ifdef QRACC_SEQ_PERF_EN
  logic        start_ok;
  logic [31:0] perf_q, perf_d;

  assign start_ok = start_i && !clear_i && ((state_q == IDLE) || (state_q == DONE));

  // Survives clear_i so software can still read the aborted job's cost.
  always_comb begin
    perf_d = perf_q;
    if (start_ok) begin
      perf_d = '0;
    end else if (busy) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = 32'd0;
`endif

  // A response with nothing in flight while a job is active means the
  // downstream block lost track of requests.
  a_resp_underflow: assert property (@(posedge clk) disable iff (rst)
    !(resp_valid_i && (outs_q == '0) && (state_q != IDLE)));

endmodule
`default_nettype wire
